bram_port_arbiter: RTL

Round-robin arbiter that shares one port of the filter's dual-port line-buffer BRAM among NREQ requesters (pixel writer, filter window readers, debug readout). It accepts one read or write per cycle, drives the BRAM port with registered enable/write/address/data, and routes returned read data back to the issuing requester with a per-requester valid. It sits between the image pipeline stages and one BRAM port; the other BRAM port is untouched.

---
 rtl/bram_port_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NREQ requesters, with read-data routing.
// Define BRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module bram_port_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned INDEXWIDTH = 9,
    parameter int unsigned WIDTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       arb_en,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            we,
    input  logic [NREQ*INDEXWIDTH-1:0] addr,
    input  logic [NREQ*WIDTH-1:0]      wdata,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            rvalid,
    output logic [WIDTH-1:0]           rdata,
    output logic                       bram_en,
    output logic                       bram_we,
    output logic                       bram_ssr,
    output logic [INDEXWIDTH-1:0]      bram_addr,
    output logic [WIDTH-1:0]           bram_din,
    input  logic [WIDTH-1:0]           bram_dout,
    input  logic                       bram_dack,
    output logic                       err
);

    localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [INDEXWIDTH-1:0] addr_a  [NREQ];
    logic [WIDTH-1:0]      wdata_a [NREQ];

    logic [PTRW-1:0]       cand;
    logic [PTRW-1:0]       gnt_idx;
    logic                  gnt_any;
    logic                  sel_we;
    logic [INDEXWIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_din;

    logic                  s1_valid;
    logic                  s2_valid;
    logic [PTRW-1:0]       s1_idx;
    logic [PTRW-1:0]       s2_idx;

    // Unpack the flat request buses so the grant mux indexes by requester number.
    for (genvar g = 0; g < int'(NREQ); g++) begin : g_unpack
        assign addr_a[g]  = addr[g*INDEXWIDTH +: INDEXWIDTH];
        assign wdata_a[g] = wdata[g*WIDTH +: WIDTH];
    end

`ifndef BRAM_ARB_FIXED_PRIO_EN
    logic [PTRW-1:0] ptr;

    // Search starts just past the last winner so every requester gets a turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == PTRW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`endif

    always_comb begin
        gnt      = '0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand     = '0;
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_din  = '0;
        if (arb_en) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
                cand = PTRW'(k);
`else
                cand = PTRW'((32'(ptr) + k) % NREQ);
`endif
                if (!gnt_any && req[cand]) begin
                    gnt[cand] = 1'b1;
                    gnt_any   = 1'b1;
                    gnt_idx   = cand;
                    sel_we    = we[cand];
                    sel_addr  = addr_a[cand];
                    sel_din   = wdata_a[cand];
                end
            end
        end
    end

    // Issue register: address and data hold between accesses to save toggling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else if (gnt_any) begin
            bram_en   <= 1'b1;
            bram_we   <= sel_we;
            bram_addr <= sel_addr;
            bram_din  <= sel_din;
        end else begin
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
        end
    end

    // Read tags line up with the BRAM's data return two cycles after the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s2_valid <= 1'b0;
            s2_idx   <= '0;
            err      <= 1'b0;
        end else begin
            s1_valid <= gnt_any & ~sel_we;
            s1_idx   <= gnt_idx;
            s2_valid <= s1_valid;
            s2_idx   <= s1_idx;
            if (s2_valid && !bram_dack) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        rvalid = '0;
        if (s2_valid && bram_dack) begin
            rvalid[s2_idx] = 1'b1;
        end
    end

    assign rdata    = bram_dout;
    assign bram_ssr = 1'b0;

endmodule
